// File: rtl/mem_probe_pkg.sv
// Shared types and helpers for the memory probe controller.
// FSM encoding, pending-move counter sizing and lane math.
package mem_probe_pkg;

   typedef enum logic {
      IDLE,
      REQ
   } probe_state_t;

   localparam int PEND_W = 4;
   localparam int PEND_LIM = 7;

   function automatic int lane_count(input int data_w, input int led_w);
      return data_w / led_w;
   endfunction

endpackage

// File: rtl/probe_addr_step.sv
// Combinational single-step address unit with wrap/saturate bounds.
// Arithmetic is one bit wider than the address to catch overflow.
module probe_addr_step #(
   parameter int          ADDR_W   = 24,
   parameter int unsigned ADDR_MIN = 0,
   parameter int unsigned ADDR_MAX = 2**24-1,
   parameter int          WRAP     = 1
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              dir,
   input  logic [4:0]        step_log2,
   output logic [ADDR_W-1:0] addr_nx
);

   localparam logic [ADDR_W:0] MIN_X = (ADDR_W+1)'(ADDR_MIN);
   localparam logic [ADDR_W:0] MAX_X = (ADDR_W+1)'(ADDR_MAX);
   localparam logic            WRAP_EN = (WRAP != 0);

   logic [4:0]      sh;
   logic [ADDR_W:0] step;
   logic [ADDR_W:0] ax;
   logic [ADDR_W:0] sum;
   logic [ADDR_W:0] res;

   always_comb begin
      sh = step_log2;
      if (int'(step_log2) >= ADDR_W) begin
         sh = 5'(ADDR_W-1);
      end
      step = (ADDR_W+1)'(1) << sh;
      ax = {1'b0, addr};
      sum = ax + step;
      res = ax;
      if (dir) begin
         if (sum > MAX_X) begin
            res = WRAP_EN ? MIN_X : MAX_X;
         end else begin
            res = sum;
         end
      end else begin
         if (ax < MIN_X + step) begin
            res = WRAP_EN ? MAX_X : MIN_X;
         end else begin
            res = ax - step;
         end
      end
      addr_nx = res[ADDR_W-1:0];
   end

endmodule

// File: rtl/mem_probe_ctrl.sv
// Probe address stepper issuing single-word DDR reads over req/ack,
// with timeout guard, queued moves while busy and auto-scan.
module mem_probe_ctrl
   import mem_probe_pkg::*;
#(
   parameter int          ADDR_W    = 24,
   parameter int          DATA_W    = 16,
   parameter int          LED_W     = 8,
   parameter int unsigned ADDR_MIN  = 0,
   parameter int unsigned ADDR_MAX  = 2**24-1,
   parameter int          WRAP      = 1,
   parameter int          AUTO_READ = 1,
   parameter int          SCAN_DIV  = 1_000_000,
   parameter int          TIMEOUT   = 255,
   localparam int LANES = lane_count(DATA_W, LED_W),
   localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              incr,
   input  logic              decr,
   input  logic              readNow,
   input  logic              scanEn,
   input  logic [4:0]        stepLog2,
   input  logic [SEL_W-1:0]  laneSel,
   output logic [ADDR_W-1:0] readAddress,
   output logic              readReq,
   input  logic              readAck,
   input  logic [DATA_W-1:0] readData,
   output logic [LED_W-1:0]  led,
   output logic              dataValid,
   output logic              busy,
   output logic              timeoutErr
);

   localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int TO_W = $clog2(TIMEOUT+1);
   localparam logic AUTO_RD = (AUTO_READ != 0);
   localparam logic signed [PEND_W-1:0] P_HI = PEND_W'(PEND_LIM);
   localparam logic signed [PEND_W-1:0] P_LO = -P_HI;

   probe_state_t state, state_nx;

   logic [ADDR_W-1:0]        addr_q;
   logic [ADDR_W-1:0]        step_addr;
   logic signed [PEND_W-1:0] pend_q, pend_nx, pend_dec;
   logic                     pend_rd_q, pend_rd_nx;
   logic [DATA_W-1:0]        cap_q;
   logic                     dv_q;
   logic                     terr_q;
   logic [TO_W-1:0]          to_q, to_nx;
   logic [SC_W-1:0]          sc_q;

   logic scan_tick;
   logic up_src;
   logic mv_up;
   logic mv_dn;
   logic move_en;
   logic step_dir;
   logic rd_trig;
   logic cap_en;
   logic to_fire;

   // Scan tick counts as an incr, so it cancels against decr.
   assign scan_tick = scanEn && (sc_q == SC_W'(SCAN_DIV-1));
   assign up_src = incr | scan_tick;
   assign mv_up = up_src & ~decr;
   assign mv_dn = decr & ~up_src;

   probe_addr_step #(
      .ADDR_W   (ADDR_W),
      .ADDR_MIN (ADDR_MIN),
      .ADDR_MAX (ADDR_MAX),
      .WRAP     (WRAP)
   ) u_step (
      .addr      (addr_q),
      .dir       (step_dir),
      .step_log2 (stepLog2),
      .addr_nx   (step_addr)
   );

   always_comb begin
      state_nx = state;
      pend_nx = pend_q;
      pend_dec = pend_q[PEND_W-1] ? pend_q + PEND_W'(1)
                                  : pend_q - PEND_W'(1);
      pend_rd_nx = pend_rd_q;
      move_en = 1'b0;
      step_dir = mv_up;
      rd_trig = 1'b0;
      cap_en = 1'b0;
      to_fire = 1'b0;
      to_nx = '0;
      unique case (state)
         IDLE: begin
            if (pend_q != '0) begin
               move_en = 1'b1;
               step_dir = ~pend_q[PEND_W-1];
               if (mv_up) begin
                  pend_nx = pend_dec + PEND_W'(1);
               end else if (mv_dn) begin
                  pend_nx = pend_dec - PEND_W'(1);
               end else begin
                  pend_nx = pend_dec;
               end
            end else if (mv_up | mv_dn) begin
               move_en = 1'b1;
            end
            rd_trig = pend_rd_q | readNow | (move_en & AUTO_RD);
            // Reads wait until every queued step has landed.
            if (rd_trig && pend_nx == '0) begin
               state_nx = REQ;
               pend_rd_nx = 1'b0;
            end else begin
               pend_rd_nx = rd_trig;
            end
         end
         REQ: begin
            if (mv_up && pend_q != P_HI) begin
               pend_nx = pend_q + PEND_W'(1);
            end else if (mv_dn && pend_q != P_LO) begin
               pend_nx = pend_q - PEND_W'(1);
            end
            pend_rd_nx = pend_rd_q | readNow;
            if (readAck) begin
               cap_en = 1'b1;
               state_nx = IDLE;
            end else if (to_q == TO_W'(TIMEOUT-1)) begin
               to_fire = 1'b1;
               state_nx = IDLE;
            end else begin
               to_nx = to_q + TO_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= IDLE;
         addr_q <= ADDR_W'(ADDR_MIN);
         pend_q <= '0;
         pend_rd_q <= 1'b0;
         cap_q <= '0;
         dv_q <= 1'b0;
         terr_q <= 1'b0;
         to_q <= '0;
         sc_q <= '0;
      end else begin
         state <= state_nx;
         pend_q <= pend_nx;
         pend_rd_q <= pend_rd_nx;
         to_q <= to_nx;
         if (move_en) begin
            addr_q <= step_addr;
         end
         if (cap_en) begin
            cap_q <= readData;
         end
         if (cap_en) begin
            dv_q <= 1'b1;
         end else if (move_en || to_fire) begin
            dv_q <= 1'b0;
         end
         if (to_fire) begin
            terr_q <= 1'b1;
         end
         if (!scanEn || scan_tick) begin
            sc_q <= '0;
         end else begin
            sc_q <= sc_q + SC_W'(1);
         end
      end
   end

   always_comb begin
      led = cap_q[LED_W-1:0];
      for (int i = 0; i < LANES; i++) begin
         if (SEL_W'(i) == laneSel) begin
            led = cap_q[i*LED_W +: LED_W];
         end
      end
   end

   assign readAddress = addr_q;
   assign readReq = (state == REQ);
   assign busy = (state == REQ);
   assign dataValid = dv_q;
   assign timeoutErr = terr_q;

endmodule

// File: tb/tb_mem_probe_ctrl.sv
// Directed bench for mem_probe_ctrl: one wrapping and one saturating
// instance, hand-computed expectations, immediate assertions.
module tb_mem_probe_ctrl;

   logic        clk;
   logic        rstN;
   logic        incr_a, decr_a, rd_a, scan_a;
   logic [4:0]  step_a;
   logic        lane_a;
   logic        man_ack, auto_a;
   logic        ack_a, req_a, dv_a, busy_a, terr_a;
   logic [23:0] addr_a;
   logic [7:0]  led_a;
   logic [15:0] rdata;

   logic        incr_b, decr_b, rd_b, scan_b;
   logic [4:0]  step_b;
   logic        lane_b;
   logic        ack_b, req_b, dv_b, busy_b, terr_b;
   logic [23:0] addr_b;
   logic [7:0]  led_b;

   int total = 0;
   int bad = 0;
   int cnt;

   assign ack_a = auto_a ? req_a : man_ack;
   assign ack_b = req_b;

   mem_probe_ctrl #(
      .ADDR_MAX (100),
      .WRAP     (1),
      .SCAN_DIV (4),
      .TIMEOUT  (255)
   ) u_a (
      .clk         (clk),
      .rstN        (rstN),
      .incr        (incr_a),
      .decr        (decr_a),
      .readNow     (rd_a),
      .scanEn      (scan_a),
      .stepLog2    (step_a),
      .laneSel     (lane_a),
      .readAddress (addr_a),
      .readReq     (req_a),
      .readAck     (ack_a),
      .readData    (rdata),
      .led         (led_a),
      .dataValid   (dv_a),
      .busy        (busy_a),
      .timeoutErr  (terr_a)
   );

   mem_probe_ctrl #(
      .ADDR_MAX (100),
      .WRAP     (0),
      .SCAN_DIV (4),
      .TIMEOUT  (255)
   ) u_b (
      .clk         (clk),
      .rstN        (rstN),
      .incr        (incr_b),
      .decr        (decr_b),
      .readNow     (rd_b),
      .scanEn      (scan_b),
      .stepLog2    (step_b),
      .laneSel     (lane_b),
      .readAddress (addr_b),
      .readReq     (req_b),
      .readAck     (ack_b),
      .readData    (rdata),
      .led         (led_b),
      .dataValid   (dv_b),
      .busy        (busy_b),
      .timeoutErr  (terr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic move_a(input logic up, input logic [4:0] s);
      step_a = s;
      if (up) incr_a = 1'b1;
      else decr_a = 1'b1;
      @(negedge clk);
      incr_a = 1'b0;
      decr_a = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic move_b(input logic up, input logic [4:0] s);
      step_b = s;
      if (up) incr_b = 1'b1;
      else decr_b = 1'b1;
      @(negedge clk);
      incr_b = 1'b0;
      decr_b = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_rd();
      rd_a = 1'b1;
      @(negedge clk);
      rd_a = 1'b0;
   endtask

   initial begin
      rstN = 1'b0;
      incr_a = 0; decr_a = 0; rd_a = 0; scan_a = 0;
      step_a = 0; lane_a = 0; auto_a = 0; man_ack = 1'b1;
      incr_b = 0; decr_b = 0; rd_b = 0; scan_b = 0;
      step_b = 0; lane_b = 0;
      rdata = 16'hFFFF;

      // reset with ack stuck high
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      chk("rst_addr", addr_a, 0);
      chk("rst_req", req_a, 0);
      chk("rst_led", led_a, 0);
      chk("rst_terr", terr_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_addr_b", addr_b, 0);
      @(negedge clk);
      chk("rst_nocap_dv", dv_a, 0);
      chk("rst_nocap_led", led_a, 0);
      man_ack = 1'b0;

      // single read, ack in 4th request cycle
      rdata = 16'hA55A;
      lane_a = 1'b1;
      step_a = 0;
      incr_a = 1'b1;
      @(negedge clk);
      incr_a = 1'b0;
      chk("rd_addr", addr_a, 1);
      chk("rd_dv_low", dv_a, 0);
      for (int i = 0; i < 4; i++) begin
         chk("rd_req_hi", req_a, 1);
         if (i == 3) man_ack = 1'b1;
         @(negedge clk);
      end
      man_ack = 1'b0;
      chk("rd_req_lo", req_a, 0);
      chk("rd_dv", dv_a, 1);
      chk("rd_led1", led_a, 8'hA5);
      chk("rd_busy", busy_a, 0);
      lane_a = 1'b0;
      #1;
      chk("rd_led0", led_a, 8'h5A);

      // wrap bounds on A, saturate bounds on B
      auto_a = 1'b1;
      move_a(1, 6);
      move_a(1, 5);
      move_a(1, 0);
      chk("wrap_pre", addr_a, 98);
      move_a(1, 2);
      chk("wrap_up", addr_a, 0);
      move_a(0, 0);
      chk("wrap_dn", addr_a, 100);
      move_a(1, 0);
      chk("wrap_up1", addr_a, 0);
      move_b(1, 6);
      move_b(1, 5);
      move_b(1, 1);
      chk("sat_pre", addr_b, 98);
      move_b(1, 2);
      chk("sat_up", addr_b, 100);
      move_b(0, 6);
      move_b(0, 5);
      chk("sat_mid", addr_b, 4);
      move_b(0, 3);
      chk("sat_dn", addr_b, 0);
      move_b(0, 0);
      chk("sat_dn0", addr_b, 0);
      auto_a = 1'b0;

      // incr+decr together: no move, no read
      chk("both_dv_pre", dv_a, 1);
      incr_a = 1'b1;
      decr_a = 1'b1;
      @(negedge clk);
      incr_a = 1'b0;
      decr_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("both_noreq", req_a, 0);
         @(negedge clk);
      end
      chk("both_addr", addr_a, 0);
      chk("both_dv", dv_a, 1);

      // three incr while busy are queued
      step_a = 0;
      pulse_rd();
      chk("q_busy", busy_a, 1);
      for (int k = 0; k < 3; k++) begin
         incr_a = 1'b1;
         @(negedge clk);
         incr_a = 1'b0;
         @(negedge clk);
      end
      chk("q_frozen", addr_a, 0);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      chk("q_ack_req", req_a, 0);
      chk("q_ack_dv", dv_a, 1);
      chk("q_ack_addr", addr_a, 0);
      @(negedge clk);
      chk("q_s1", addr_a, 1);
      chk("q_s1_dv", dv_a, 0);
      chk("q_s1_req", req_a, 0);
      @(negedge clk);
      chk("q_s2", addr_a, 2);
      chk("q_s2_req", req_a, 0);
      @(negedge clk);
      chk("q_s3", addr_a, 3);
      chk("q_s3_req", req_a, 1);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      chk("q_done_req", req_a, 0);
      chk("q_done_dv", dv_a, 1);
      repeat (2) begin
         @(negedge clk);
         chk("q_one_read", req_a, 0);
      end
      chk("q_final", addr_a, 3);

      // timeout with no ack
      incr_a = 1'b1;
      @(negedge clk);
      incr_a = 1'b0;
      cnt = 0;
      while (req_a && cnt < 400) begin
         cnt++;
         @(negedge clk);
      end
      chk("to_len", cnt, 255);
      chk("to_err", terr_a, 1);
      chk("to_dv", dv_a, 0);
      chk("to_addr", addr_a, 4);

      // later read works; error stays sticky
      auto_a = 1'b1;
      rdata = 16'h1234;
      lane_a = 1'b1;
      pulse_rd();
      @(negedge clk);
      @(negedge clk);
      chk("post_dv", dv_a, 1);
      chk("post_led", led_a, 8'h12);
      chk("post_terr", terr_a, 1);
      chk("post_busy", busy_a, 0);

      // auto-scan every 4 cycles with immediate acks
      scan_a = 1'b1;
      cnt = 0;
      while (addr_a == 24'd4 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("scan_first", cnt, 4);
      for (int p = 0; p < 3; p++) begin
         chk("scan_addr", addr_a, 24'(5 + p));
         chk("scan_req", req_a, 1);
         chk("scan_dv_lo", dv_a, 0);
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("scan_idle_req", req_a, 0);
            chk("scan_dv_hi", dv_a, 1);
         end
         @(negedge clk);
      end
      scan_a = 1'b0;
      repeat (3) @(negedge clk);
      chk("scan_stop", addr_a, 8);
      auto_a = 1'b0;

      // reset mid-request, then late ack
      pulse_rd();
      chk("mr_req", req_a, 1);
      rstN = 1'b0;
      #1;
      chk("mr_req_drop", req_a, 0);
      chk("mr_addr", addr_a, 0);
      man_ack = 1'b1;
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("mr_late_req", req_a, 0);
      chk("mr_late_dv", dv_a, 0);
      chk("mr_late_led", led_a, 0);
      chk("mr_terr", terr_a, 0);
      man_ack = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
